// File: rtl/if_id_fetch_buffer_if.sv
// Purpose : IF->ID handshake bundle for the fetch buffer (push side, pop side, flush, occupancy).
// Ports   : master = IF/ID/EXE-facing driver view, slave = buffer view.
// Signals : flush, in_valid/in_pc/in_instr/in_ready, out_valid/out_pc/out_instr/out_ready, count[AW:0].
interface if_id_fetch_buffer_if #(
  parameter int AW = 1
);
  logic          flush;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic [AW:0]   count;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/if_id_fetch_buffer.sv
// Purpose : DEPTH-entry FIFO decoupling IF from ID; flush (taken branch) drops every held entry.
// Latency : a pair pushed on edge N appears on out_* after edge N; no in->out bypass.
// Ports   : clk, rst (async active-low), bus (slave): in_ready depends on count only, out_* zero when empty.
module if_id_fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  if_id_fetch_buffer_if.slave  bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  pair_t         mem_q [DEPTH];
  pair_t         mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push;
  logic          pop;
  pair_t         head;

  always_comb begin
    // Full blocks a push even when a pop happens in the same cycle:
    // the freed slot only becomes usable on the following cycle.
    push    = bus.in_valid && (count_q != FULL_CNT) && !bus.flush;
    pop     = (count_q != '0) && bus.out_ready && !bus.flush;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (bus.flush) begin
      // The pair offered in the flush cycle is the wrong-path fetch and is dropped.
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = '{pc: bus.in_pc, instr: bus.in_instr};
        wptr_d        = wptr_q + AW'(1);   // DEPTH is a power of two, so this wraps naturally
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign head          = mem_q[rptr_q];
  assign bus.in_ready  = (count_q != FULL_CNT);
  assign bus.out_valid = (count_q != '0);
  // Empty presents a NOP bubble (all zeros) to ID.
  assign bus.out_pc    = bus.out_valid ? head.pc    : 32'h0;
  assign bus.out_instr = bus.out_valid ? head.instr : 32'h0;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
module tb_if_id_fetch_buffer;

  localparam int DEPTH = 2;
  localparam int AW    = 1;

  typedef struct packed {
    logic        flush;
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_cmp;
  int   n_err;
  ent_t mq[$];
  vec_t tbl[22];

  if_id_fetch_buffer_if #(.AW(AW)) bus ();

  if_id_fetch_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc == 32'h0) ? 32'h0 : (32'hA000_0000 | (pc >> 2));
  endfunction

  function automatic vec_t mk(input logic fl, input logic iv, input int pc, input logic ordy,
                              input logic e_rdy, input logic e_ov, input int e_pc, input int e_cnt);
    vec_t v;
    v.flush = fl;     v.iv = iv;         v.pc = 32'(pc);     v.ordy = ordy;
    v.e_rdy = e_rdy;  v.e_ov = e_ov;     v.e_pc = 32'(e_pc); v.e_cnt = 32'(e_cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, update the scoreboard from the driven inputs, then check
  // the row's expected post-edge outputs.
  task automatic apply(input string tag, input vec_t v);
    ent_t e;
    bit   can_push;
    @(negedge clk);
    bus.flush     = v.flush;
    bus.in_valid  = v.iv;
    bus.in_pc     = v.pc;
    bus.in_instr  = instr_of(v.pc);
    bus.out_ready = v.ordy;
    #1;
    can_push = (mq.size() < DEPTH);
    if (v.flush) begin
      mq.delete();
    end else begin
      if (v.ordy && mq.size() > 0) begin
        e = mq.pop_front();
        chk({tag, "_sb_pc"},    bus.out_pc,    e.pc);
        chk({tag, "_sb_instr"}, bus.out_instr, e.instr);
      end
      if (v.iv && can_push) begin
        e.pc    = v.pc;
        e.instr = instr_of(v.pc);
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    n_vec++;
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(v.e_rdy));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(v.e_ov));
    chk({tag, "_out_pc"},    bus.out_pc,         v.e_ov ? v.e_pc : 32'h0);
    chk({tag, "_out_instr"}, bus.out_instr,      v.e_ov ? instr_of(v.e_pc) : 32'h0);
    chk({tag, "_count"},     32'(bus.count),     v.e_cnt);
    chk({tag, "_sb_count"},  32'(bus.count),     32'(mq.size()));
  endtask

  initial begin
    n_vec = 0;
    n_cmp = 0;
    n_err = 0;

    // flush, in_valid, pc, out_ready | in_ready, out_valid, out_pc, count
    // reset then streaming with out_ready held high
    tbl[0]  = mk(0, 1,   4, 1,  1, 1,  4, 1);
    tbl[1]  = mk(0, 1,   8, 1,  1, 1,  8, 1);
    tbl[2]  = mk(0, 1,  12, 1,  1, 1, 12, 1);
    tbl[3]  = mk(0, 0,   0, 1,  1, 0,  0, 0);
    // fill and stall; pc=12 refused while full, even with a pop in that cycle
    tbl[4]  = mk(0, 1,   4, 0,  1, 1,  4, 1);
    tbl[5]  = mk(0, 1,   8, 0,  0, 1,  4, 2);
    tbl[6]  = mk(0, 1,  12, 0,  0, 1,  4, 2);
    tbl[7]  = mk(0, 1,  12, 1,  1, 1,  8, 1);
    // flush while full, with a wrong-path push and a pop request
    tbl[8]  = mk(0, 1,  12, 0,  0, 1,  8, 2);
    tbl[9]  = mk(1, 1, 100, 1,  1, 0,  0, 0);
    tbl[10] = mk(0, 0,   0, 0,  1, 0,  0, 0);
    // simultaneous push/pop across pointer wrap, count held at 1
    tbl[11] = mk(0, 1,   4, 0,  1, 1,  4, 1);
    tbl[12] = mk(0, 1,   8, 1,  1, 1,  8, 1);
    tbl[13] = mk(0, 1,  12, 1,  1, 1, 12, 1);
    tbl[14] = mk(0, 1,  16, 1,  1, 1, 16, 1);
    tbl[15] = mk(0, 1,  20, 1,  1, 1, 20, 1);
    tbl[16] = mk(0, 0,   0, 1,  1, 0,  0, 0);
    // pop on empty
    tbl[17] = mk(0, 0,   0, 1,  1, 0,  0, 0);
    tbl[18] = mk(0, 0,   0, 1,  1, 0,  0, 0);
    tbl[19] = mk(0, 0,   0, 1,  1, 0,  0, 0);
    // refill ahead of the asynchronous reset
    tbl[20] = mk(0, 1,   4, 0,  1, 1,  4, 1);
    tbl[21] = mk(0, 1,   8, 0,  0, 1,  4, 2);

    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = 32'h0;
    bus.in_instr  = 32'h0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_pc",    bus.out_pc,         32'h0);
    chk("rst_out_instr", bus.out_instr,      32'h0);
    chk("rst_count",     32'(bus.count),     32'h0);
    rst = 1'b1;
    #1;
    chk("rel_in_ready",  32'(bus.in_ready),  32'h1);

    for (int i = 0; i < 22; i++) begin
      apply($sformatf("v%0d", i), tbl[i]);
    end

    // asynchronous reset between edges with two entries held
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_count",     32'(bus.count),     32'h0);
    chk("arst_out_instr", bus.out_instr,      32'h0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'h1);
    mq.delete();
    @(negedge clk);
    rst = 1'b1;

    apply("post0", mk(0, 0,  0, 1,  1, 0,  0, 0));
    apply("post1", mk(0, 1, 40, 0,  1, 1, 40, 1));
    apply("post2", mk(0, 0,  0, 1,  1, 0,  0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
